// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the seven-segment digit scanner.
// Imported by the slot timer and the scanner top level.
package seg_scan_pkg;

    localparam int CODE_W = 3;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

    // Width of a digit index; a single-bit index is kept even for tiny displays.
    function automatic int idx_width(input int numDigits);
        return (numDigits <= 2) ? 1 : $clog2(numDigits);
    endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// Per-digit slot timer: counts cycles within a slot and tracks BLANK/SHOW.
// The count names the slot cycle that the scanner's output registers present next.
module seg_slot_timer
    import seg_scan_pkg::*;
#(
    parameter  int REFRESH_DIV  = 1000,
    parameter  int BLANK_CYCLES = 50,
    localparam int CNT_W        = (REFRESH_DIV <= 2) ? 1 : $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] o_count,
    output scan_state_t      o_state,
    output logic             o_slot_end
);

    logic [CNT_W-1:0] r_count;
    scan_state_t      r_state;
    logic             w_slotEnd;
    logic             w_blankDone;

    assign w_slotEnd   = (r_count == CNT_W'(REFRESH_DIV - 1));
    assign w_blankDone = (r_count == CNT_W'(BLANK_CYCLES - 1));

    // State always agrees with the count: BLANK below BLANK_CYCLES, SHOW after.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_state <= ST_BLANK;
        end else if (w_slotEnd) begin
            r_count <= '0;
            r_state <= ST_BLANK;
        end else begin
            r_count <= r_count + 1'b1;
            if (w_blankDone) begin
                r_state <= ST_SHOW;
            end
        end
    end

    assign o_count    = r_count;
    assign o_state    = r_state;
    assign o_slot_end = w_slotEnd;

endmodule

// File: rtl/seg_digit_scanner.sv
// Multiplexes per-digit 3-bit codes onto one decoder with one-hot digit enables.
// Writes go to a shadow bank; a commit copies it to the active bank at a frame boundary.
module seg_digit_scanner
    import seg_scan_pkg::*;
#(
    parameter  int NUM_DIGITS   = 4,
    parameter  int REFRESH_DIV  = 1000,
    parameter  int BLANK_CYCLES = 50,
    localparam int IDX_W        = idx_width(NUM_DIGITS),
    localparam int CNT_W        = (REFRESH_DIV <= 2) ? 1 : $clog2(REFRESH_DIV)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_addr,
    input  logic [CODE_W-1:0]     wr_data,
    input  logic                  commit,
    output logic                  commit_pending,
    output logic [CODE_W-1:0]     digit_code,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_start
);

    logic [CODE_W-1:0]     r_shadow [NUM_DIGITS];
    logic [CODE_W-1:0]     r_active [NUM_DIGITS];
    logic [IDX_W-1:0]      r_index;
    logic                  r_pending;
    logic [CODE_W-1:0]     r_digitCode;
    logic [NUM_DIGITS-1:0] r_digEn;
    logic                  r_frameStart;

    logic [CNT_W-1:0]      w_count;
    scan_state_t           w_state;
    logic                  w_slotEnd;
    logic                  w_frameBoundary;
    logic                  w_doCopy;
    logic                  w_lastIndex;
    logic                  w_writeOk;
    logic [NUM_DIGITS-1:0] w_oneHot;

    seg_slot_timer #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk        (clk),
        .rst        (rst),
        .o_count    (w_count),
        .o_state    (w_state),
        .o_slot_end (w_slotEnd)
    );

    assign w_frameBoundary = (w_count == '0) && (r_index == '0);
    assign w_doCopy        = w_frameBoundary && r_pending;
    assign w_lastIndex     = (r_index == IDX_W'(NUM_DIGITS - 1));
    assign w_writeOk       = wr_en && ({1'b0, wr_addr} < (IDX_W + 1)'(NUM_DIGITS));
    assign w_oneHot        = NUM_DIGITS'(1) << r_index;

    // The copy reads shadow before this edge's write lands, so a coincident write waits for the next commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (w_doCopy) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (w_writeOk) begin
                r_shadow[wr_addr] <= wr_data;
            end
        end
    end

    // Outputs are loaded from the upcoming slot position, so the freshly copied code shows in the boundary cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index      <= '0;
            r_pending    <= 1'b0;
            r_digitCode  <= '0;
            r_digEn      <= '0;
            r_frameStart <= 1'b0;
        end else begin
            if (w_slotEnd) begin
                r_index <= w_lastIndex ? '0 : r_index + 1'b1;
            end
            r_pending    <= w_doCopy ? 1'b0 : (r_pending | commit);
            r_frameStart <= w_frameBoundary;
            r_digitCode  <= w_doCopy ? r_shadow[r_index] : r_active[r_index];
            r_digEn      <= (w_state == ST_SHOW) ? w_oneHot : '0;
        end
    end

    assign commit_pending = r_pending;
    assign digit_code     = r_digitCode;
    assign dig_en         = r_digEn;
    assign frame_start    = r_frameStart;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Bench for seg_digit_scanner: a 4-digit and a 3-digit instance share stimulus
// and are compared every cycle against a frame/slot arithmetic reference model.
module tb_seg_digit_scanner;

    localparam int R = 8;
    localparam int B = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       wrEn;
    logic [1:0] wrAddr;
    logic [2:0] wrData;
    logic       commit;

    logic       pendA, pendB, fsA, fsB;
    logic [2:0] codeA, codeB;
    logic [3:0] enA;
    logic [2:0] enB;

    int checks = 0;
    int errors = 0;

    int numD [2] = '{4, 3};
    int mShadow [2][4];
    int mActive [2][4];
    bit mPend [2];
    int mCycle [2];

    always #5 clk = ~clk;

    seg_digit_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dutA (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .commit(commit), .commit_pending(pendA), .digit_code(codeA), .dig_en(enA),
        .frame_start(fsA)
    );

    seg_digit_scanner #(.NUM_DIGITS(3), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dutB (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_addr(wrAddr), .wr_data(wrData),
        .commit(commit), .commit_pending(pendB), .digit_code(codeB), .dig_en(enB),
        .frame_start(fsB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit we, input int addr, input int data, input bit cm);
        wrEn   = we;
        wrAddr = 2'(addr);
        wrData = 3'(data);
        commit = cm;
    endtask

    task automatic resetModel();
        for (int d = 0; d < 2; d++) begin
            mCycle[d] = -1;
            mPend[d]  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                mShadow[d][i] = 0;
                mActive[d][i] = 0;
            end
        end
    endtask

    // One clock edge of the display as described in words: frame boundaries every N*R cycles,
    // commit copies shadow there, writes land in shadow afterwards.
    task automatic modelEdge(input int d);
        int frame;
        frame = numD[d] * R;
        mCycle[d]++;
        if ((mCycle[d] % frame == 0) && mPend[d]) begin
            for (int i = 0; i < 4; i++) mActive[d][i] = mShadow[d][i];
            mPend[d] = 1'b0;
        end else if (commit) begin
            mPend[d] = 1'b1;
        end
        if (wrEn && (int'(wrAddr) < numD[d])) mShadow[d][wrAddr] = int'(wrData);
    endtask

    task automatic checkDut(input int d);
        int k, idx, expEn, expFs;
        string p;
        p     = (d == 0) ? "A" : "B";
        k     = mCycle[d] % R;
        idx   = (mCycle[d] / R) % numD[d];
        expEn = (k >= B) ? (1 << idx) : 0;
        expFs = (mCycle[d] % (numD[d] * R) == 0) ? 1 : 0;
        checkOutput({p, ".dig_en"}, (d == 0) ? 32'(enA) : 32'(enB), 32'(expEn));
        checkOutput({p, ".digit_code"}, (d == 0) ? 32'(codeA) : 32'(codeB), 32'(mActive[d][idx]));
        checkOutput({p, ".frame_start"}, (d == 0) ? 32'(fsA) : 32'(fsB), 32'(expFs));
        checkOutput({p, ".commit_pending"}, (d == 0) ? 32'(pendA) : 32'(pendB), 32'(mPend[d]));
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, ".A.dig_en"}, 32'(enA), 0);
        checkOutput({tag, ".A.digit_code"}, 32'(codeA), 0);
        checkOutput({tag, ".A.commit_pending"}, 32'(pendA), 0);
        checkOutput({tag, ".A.frame_start"}, 32'(fsA), 0);
        checkOutput({tag, ".B.dig_en"}, 32'(enB), 0);
        checkOutput({tag, ".B.commit_pending"}, 32'(pendB), 0);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        if (!rst) begin
            modelEdge(0);
            modelEdge(1);
        end
        #1;
        if (!rst) begin
            checkDut(0);
            checkDut(1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0);
            stepCycle();
        end
    endtask

    initial begin
        int reached;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0);
        resetModel();
        #2;
        checkZero("por");
        stepCycle();
        stepCycle();
        rst = 1'b0;

        // First frame with empty banks, then load 3,5,7,1 and commit.
        idle(10);
        applyStimulus(1, 0, 3, 0); stepCycle();
        applyStimulus(1, 1, 5, 0); stepCycle();
        applyStimulus(1, 2, 7, 0); stepCycle();
        applyStimulus(1, 3, 1, 0); stepCycle();
        applyStimulus(0, 0, 0, 1); stepCycle();
        applyStimulus(0, 0, 0, 1); stepCycle();
        idle(70);

        // Shadow-only write must not reach the display.
        applyStimulus(1, 2, 4, 0); stepCycle();
        idle(70);

        // Commit pending, then write digit 1 in A's boundary cycle.
        applyStimulus(0, 0, 0, 1); stepCycle();
        reached = 0;
        for (int i = 0; i < 40 && reached == 0; i++) begin
            if (mCycle[0] % (4 * R) == 0) reached = 1;
            else begin
                applyStimulus(0, 0, 0, 0);
                stepCycle();
            end
        end
        checkOutput("reach.boundary", 32'(reached), 1);
        applyStimulus(1, 1, 6, 0); stepCycle();
        idle(40);
        applyStimulus(0, 0, 0, 1); stepCycle();
        idle(40);

        // Asynchronous reset in the middle of digit 2's SHOW window, with a commit pending.
        reached = 0;
        for (int i = 0; i < 80 && reached == 0; i++) begin
            if (((mCycle[0] / R) % 4 == 2) && (mCycle[0] % R == 3)) reached = 1;
            else begin
                applyStimulus(0, 0, 0, 0);
                stepCycle();
            end
        end
        checkOutput("reach.show2", 32'(reached), 1);
        applyStimulus(0, 0, 0, 1); stepCycle();
        applyStimulus(0, 0, 0, 0);
        #3;
        rst = 1'b1;
        #1;
        checkZero("async");
        resetModel();
        stepCycle();
        stepCycle();
        rst = 1'b0;
        idle(40);

        // Randomised traffic, including out-of-range addresses for the 3-digit instance.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom % 3) == 0, $urandom_range(0, 3), $urandom_range(0, 7),
                          ($urandom % 16) == 0);
            stepCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
